// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares one LEN-bit register among NUM_REQ writers.
// Optional burst lock for the previous winner is enabled with REG_ARB_LOCK_EN.
module reg_write_arbiter #(
    parameter int unsigned LEN     = 9,
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*LEN-1:0] reqData,
    input  logic [NUM_REQ-1:0]     lock,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [LEN-1:0]         dataOut,
    output logic [ID_W-1:0]        ownerId,
    output logic                   updated
);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    last_q;
    logic               last_valid_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [LEN-1:0]     data_q;
    logic [ID_W-1:0]    owner_q;
    logic               updated_q;

    logic               found;
    logic               lock_hit;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    ptr_next;
    logic [NUM_REQ-1:0] gnt_d;

    // Search ptr, ptr+1, ... modulo NUM_REQ; no power-of-two assumption.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] idx_w;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx   = (32'(ptr_q) + k) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!found && req[idx_w]) begin
                found = 1'b1;
                win   = idx_w;
            end
        end
`ifdef REG_ARB_LOCK_EN
        lock_hit = last_valid_q && lock[last_q] && req[last_q];
`else
        lock_hit = 1'b0;
`endif
        if (lock_hit) begin
            found = 1'b1;
            win   = last_q;
        end
    end

`ifndef REG_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^{lock, last_q, last_valid_q};
`endif

    always_comb begin
        gnt_d = '0;
        if (found) begin
            gnt_d[win] = 1'b1;
        end
        if (lock_hit) begin
            ptr_next = ptr_q;
        end else if (win == ID_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            gnt_q        <= '0;
            data_q       <= '0;
            owner_q      <= '0;
            updated_q    <= 1'b0;
        end else if (found) begin
            ptr_q        <= ptr_next;
            last_q       <= win;
            last_valid_q <= 1'b1;
            gnt_q        <= gnt_d;
            data_q       <= reqData[32'(win)*LEN +: LEN];
            owner_q      <= win;
            updated_q    <= 1'b1;
        end else begin
            last_valid_q <= 1'b0;
            gnt_q        <= '0;
            updated_q    <= 1'b0;
        end
    end

    assign gnt     = gnt_q;
    assign dataOut = data_q;
    assign ownerId = owner_q;
    assign updated = updated_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, then random traffic against
// a priority-order queue model.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [35:0] reqData;
    logic [3:0]  lock;
    logic [3:0]  gnt;
    logic [8:0]  dataOut;
    logic [1:0]  ownerId;
    logic        updated;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .LEN     (9),
        .NUM_REQ (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .reqData (reqData),
        .lock    (lock),
        .gnt     (gnt),
        .dataOut (dataOut),
        .ownerId (ownerId),
        .updated (updated)
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [35:0] data;
        logic [3:0]  exp_gnt;
        logic [8:0]  exp_data;
        logic [1:0]  exp_owner;
        logic        exp_upd;
    } vec_t;

    vec_t vecs[$];

    // Model: queue of indices in current priority order; a winner rotates to the back.
    int          order[$];
    logic [3:0]  m_gnt;
    logic [8:0]  m_data;
    logic [1:0]  m_owner;
    logic        m_upd;
    int          m_last;
    bit          m_lv;

    function automatic logic [35:0] pack4(input logic [8:0] d0, input logic [8:0] d1,
                                          input logic [8:0] d2, input logic [8:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] lk,
                       input logic [35:0] d, input logic [3:0] eg, input logic [8:0] ed,
                       input logic [1:0] eo, input logic eu);
        vecs.push_back('{rst, r, lk, d, eg, ed, eo, eu});
    endtask

    task automatic model_step(input logic rst, input logic [3:0] r, input logic [35:0] d,
                              input logic [3:0] lk);
        int w = -1;
        if (rst) begin
            order   = '{0, 1, 2, 3};
            m_gnt   = '0;
            m_data  = '0;
            m_owner = '0;
            m_upd   = 1'b0;
            m_last  = 0;
            m_lv    = 1'b0;
            return;
        end
`ifdef REG_ARB_LOCK_EN
        if (m_lv && lk[m_last] && r[m_last]) w = m_last;
`else
        if (lk === 4'hx) w = -1;
`endif
        if (w < 0) begin
            foreach (order[k]) begin
                if (w < 0 && r[order[k]]) w = order[k];
            end
            if (w >= 0) begin
                while (order[order.size()-1] != w) order.push_back(order.pop_front());
            end
        end
        if (w < 0) begin
            m_gnt = '0;
            m_upd = 1'b0;
            m_lv  = 1'b0;
        end else begin
            m_gnt   = 4'(1 << w);
            m_data  = d[w*9 +: 9];
            m_owner = 2'(w);
            m_upd   = 1'b1;
            m_last  = w;
            m_lv    = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [8:0] ed,
                         input logic [1:0] eo, input logic eu);
        checks++;
        if ({gnt, dataOut, ownerId, updated} !== {eg, ed, eo, eu}) begin
            errors++;
            $display("FAIL %s: got gnt=%b dataOut=%h ownerId=%0d updated=%b, want gnt=%b dataOut=%h ownerId=%0d updated=%b",
                     name, gnt, dataOut, ownerId, updated, eg, ed, eo, eu);
        end
    endtask

    task automatic drive_cycle(input logic rst, input logic [3:0] r, input logic [3:0] lk,
                               input logic [35:0] d);
        reset   = rst;
        req     = r;
        lock    = lk;
        reqData = d;
        @(posedge clk);
        model_step(rst, r, d, lk);
        #1;
    endtask

    initial begin
        logic [35:0] cont;
        logic [35:0] skip;
        logic [35:0] single;
        logic [35:0] lk_d;
        cont   = pack4(9'h010, 9'h011, 9'h012, 9'h013);
        skip   = pack4(9'h0F0, 9'h0A1, 9'h0F2, 9'h0A3);
        single = pack4(9'h055, 9'h066, 9'h1A5, 9'h077);
        lk_d   = pack4(9'h0C0, 9'h0C1, 9'h0C2, 9'h0C3);

        // Reset with all requesting
        add(1, 4'b1111, 4'b0000, cont, 4'b0000, 9'h000, 2'd0, 0);
        add(1, 4'b1111, 4'b0000, cont, 4'b0000, 9'h000, 2'd0, 0);
        // Full contention, 8 cycles
        for (int i = 0; i < 8; i++) begin
            add(0, 4'b1111, 4'b0000, cont, 4'(1 << (i % 4)), 9'(9'h010 + i % 4),
                2'(i % 4), 1);
        end
        add(0, 4'b0000, 4'b0000, cont, 4'b0000, 9'h013, 2'd3, 0);
        // Wrap and skip from ptr 0
        add(0, 4'b1010, 4'b0000, skip, 4'b0010, 9'h0A1, 2'd1, 1);
        add(0, 4'b1010, 4'b0000, skip, 4'b1000, 9'h0A3, 2'd3, 1);
        add(0, 4'b1010, 4'b0000, skip, 4'b0010, 9'h0A1, 2'd1, 1);
        add(0, 4'b0000, 4'b0000, skip, 4'b0000, 9'h0A1, 2'd1, 0);
        // Single requester
        add(0, 4'b0100, 4'b0000, single, 4'b0100, 9'h1A5, 2'd2, 1);
        add(0, 4'b0000, 4'b0000, single, 4'b0000, 9'h1A5, 2'd2, 0);
        add(0, 4'b0000, 4'b0000, single, 4'b0000, 9'h1A5, 2'd2, 0);
        // Reset mid-stream; ptr is 3 here
        add(0, 4'b1111, 4'b0000, cont, 4'b1000, 9'h013, 2'd3, 1);
        add(0, 4'b1111, 4'b0000, cont, 4'b0001, 9'h010, 2'd0, 1);
        add(0, 4'b1111, 4'b0000, cont, 4'b0010, 9'h011, 2'd1, 1);
        add(1, 4'b1111, 4'b0000, cont, 4'b0000, 9'h000, 2'd0, 0);
        add(0, 4'b1111, 4'b0000, cont, 4'b0001, 9'h010, 2'd0, 1);
        add(0, 4'b1111, 4'b0000, cont, 4'b0010, 9'h011, 2'd1, 1);
        // Lock from a clean start
        add(1, 4'b0000, 4'b0000, lk_d, 4'b0000, 9'h000, 2'd0, 0);
        add(0, 4'b0011, 4'b0001, lk_d, 4'b0001, 9'h0C0, 2'd0, 1);
`ifdef REG_ARB_LOCK_EN
        add(0, 4'b0011, 4'b0001, lk_d, 4'b0001, 9'h0C0, 2'd0, 1);
        add(0, 4'b0011, 4'b0001, lk_d, 4'b0001, 9'h0C0, 2'd0, 1);
`else
        add(0, 4'b0011, 4'b0001, lk_d, 4'b0010, 9'h0C1, 2'd1, 1);
        add(0, 4'b0011, 4'b0001, lk_d, 4'b0001, 9'h0C0, 2'd0, 1);
`endif
        add(0, 4'b0011, 4'b0000, lk_d, 4'b0010, 9'h0C1, 2'd1, 1);
        // Lock held by a non-last requester does nothing
        add(0, 4'b0011, 4'b0001, lk_d, 4'b0001, 9'h0C0, 2'd0, 1);
        add(0, 4'b0011, 4'b0010, lk_d, 4'b0010, 9'h0C1, 2'd1, 1);

        reset   = 1'b1;
        req     = '0;
        lock    = '0;
        reqData = '0;
        order   = '{0, 1, 2, 3};
        @(negedge clk);

        foreach (vecs[i]) begin
            drive_cycle(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].data);
            check($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_data,
                  vecs[i].exp_owner, vecs[i].exp_upd);
        end

        // Random traffic vs. model
        drive_cycle(1'b1, 4'b0000, 4'b0000, '0);
        check("rand_reset", m_gnt, m_data, m_owner, m_upd);
        for (int c = 0; c < 400; c++) begin
            logic        rst;
            logic [3:0]  r;
            logic [3:0]  lk;
            logic [35:0] d;
            rst = ($urandom_range(0, 39) == 0);
            r   = 4'($urandom);
            lk  = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
            d   = {4'($urandom), 32'($urandom)};
            drive_cycle(rst, r, lk, d);
            check($sformatf("rand%0d", c), m_gnt, m_data, m_owner, m_upd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
